// File: rtl/pingpong_counter_bank_pkg.sv
// pingpong_counter_bank_pkg: mode encodings shared by the counter bank and its lanes
package pingpong_counter_bank_pkg;
  typedef enum logic [1:0] {
    PP_MODE_PINGPONG  = 2'b00,
    PP_MODE_WRAP_UP   = 2'b01,
    PP_MODE_WRAP_DOWN = 2'b10,
    PP_MODE_ONESHOT   = 2'b11
  } pp_mode_t;
endpackage

// File: rtl/pingpong_counter_bank_lane.sv
// pingpong_lane: one bounded up/down counter channel with load, resync and four counting modes
module pingpong_lane
  import pingpong_counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flip,
  input  logic             load,
  input  logic             cfg_err,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] step,
  input  pp_mode_t         mode,
  output logic [WIDTH-1:0] out,
  output logic             direction,
  output logic             evt
);
  logic [WIDTH:0]   up_sum, dn_diff;
  logic [WIDTH-1:0] up_n, dn_n, out_n;
  logic             dir_n, evt_n, at_min, at_max, in_range;
  // One clamped step each way from the current count; at a bound these equal the
  // turnaround values, since then out is min or max itself.
  always_comb begin
    up_sum   = {1'b0, out} + {1'b0, step};
    dn_diff  = {1'b0, out} - {1'b0, step};
    up_n     = (up_sum > {1'b0, max}) ? max : up_sum[WIDTH-1:0];
    dn_n     = (dn_diff[WIDTH] || dn_diff[WIDTH-1:0] < min) ? min : dn_diff[WIDTH-1:0];
    at_min   = out == min;
    at_max   = out == max;
    in_range = out >= min && out <= max;
  end
  // Next-state selection in priority order: cfg hold, load, resync, degenerate range, mode step.
  always_comb begin
    out_n = out;
    dir_n = direction;
    evt_n = 1'b0;
    if (cfg_err) begin
    end else if (load) begin
      out_n = (load_val >= min && load_val <= max) ? load_val : min;
      dir_n = 1'b1;
    end else if (enable) begin
      if (!in_range) begin
        out_n = min;
        dir_n = 1'b1;
      end else if (min == max) begin
        out_n = min;
      end else if (mode == PP_MODE_PINGPONG) begin
        if (flip && !at_min && !at_max) begin
          dir_n = !direction;
          out_n = direction ? dn_n : up_n;
        end else if (direction) begin
          out_n = at_max ? dn_n : up_n;
          dir_n = !at_max;
          evt_n = at_max;
        end else begin
          out_n = at_min ? up_n : dn_n;
          dir_n = at_min;
          evt_n = at_min;
        end
      end else if (mode == PP_MODE_WRAP_UP) begin
        dir_n = 1'b1;
        out_n = at_max ? min : up_n;
        evt_n = at_max;
      end else if (mode == PP_MODE_WRAP_DOWN) begin
        dir_n = 1'b0;
        out_n = at_min ? max : dn_n;
        evt_n = at_min;
      end else begin
        dir_n = 1'b1;
        out_n = up_n;
        evt_n = !at_max && up_n == max;
      end
    end
  end
  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      direction <= 1'b1;
      evt       <= 1'b0;
    end else begin
      out       <= out_n;
      direction <= dir_n;
      evt       <= evt_n;
    end
  end
endmodule

// File: rtl/pingpong_counter_bank.sv
// pingpong_counter_bank: NCH independent bounded counters sharing bounds, step and mode
module pingpong_counter_bank
  import pingpong_counter_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH-1:0]       flip,
  input  logic [NCH-1:0]       load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [WIDTH-1:0]     min,
  input  logic [WIDTH-1:0]     max,
  input  logic [WIDTH-1:0]     step,
  input  logic [1:0]           mode,
  output logic [NCH*WIDTH-1:0] out,
  output logic [NCH-1:0]       direction,
  output logic [NCH-1:0]       evt,
  output logic                 cfg_err
);
  logic [WIDTH-1:0] step_eff;
  // Shared configuration checks, computed once for all lanes; a zero step counts as one.
  always_comb begin
    cfg_err  = min > max;
    step_eff = (step == '0) ? WIDTH'(1) : step;
  end
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    pingpong_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable[i]),
      .flip      (flip[i]),
      .load      (load[i]),
      .cfg_err   (cfg_err),
      .load_val  (load_val),
      .min       (min),
      .max       (max),
      .step      (step_eff),
      .mode      (pp_mode_t'(mode)),
      .out       (out[i*WIDTH +: WIDTH]),
      .direction (direction[i]),
      .evt       (evt[i])
    );
  end
endmodule

// File: tb/tb_pingpong_counter_bank.sv
// tb_pingpong_counter_bank: directed vector table plus async-reset / oneshot sequence
module tb_pingpong_counter_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  enable = '0, flip = '0, load = '0;
  logic [7:0]  load_val = '0, min = '0, max = '0, step = 8'd1;
  logic [1:0]  mode = '0;
  logic [31:0] out;
  logic [3:0]  direction, evt;
  logic        cfg_err;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [3:0]  en, fl, ld;
    logic [7:0]  lv, mn, mx, st;
    logic [1:0]  md;
    logic [31:0] e_out;
    logic [3:0]  e_dir, e_evt;
    logic        e_cfg;
  } vec_t;
  vec_t vq[$];

  pingpong_counter_bank #(.WIDTH(8), .NCH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .load(load),
    .load_val(load_val), .min(min), .max(max), .step(step), .mode(mode),
    .out(out), .direction(direction), .evt(evt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] en, fl, ld, input logic [7:0] lv, mn, mx, st,
                     input logic [1:0] md, input logic [31:0] eo, input logic [3:0] ed, ee,
                     input logic ec);
    vec_t v;
    v.en = en; v.fl = fl; v.ld = ld; v.lv = lv; v.mn = mn; v.mx = mx; v.st = st; v.md = md;
    v.e_out = eo; v.e_dir = ed; v.e_evt = ee; v.e_cfg = ec;
    vq.push_back(v);
  endtask

  initial begin
    int nevt;
    // pingpong [2,6] step 1 from reset: resync, climb, turnarounds
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h02,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h03,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h04,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h05,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h06,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h05,4'hE,4'h1,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h04,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h03,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h02,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h03,4'hF,4'h1,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h04,4'hF,4'h0,0);
    // flip mid-range, then flip at max ignored
    add(4'h1,4'h1,4'h0,  0, 2,  6,1,2'd0,32'h03,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h02,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h03,4'hF,4'h1,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h04,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h05,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h06,4'hF,4'h0,0);
    add(4'h1,4'h1,4'h0,  0, 2,  6,1,2'd0,32'h05,4'hE,4'h1,0);
    // step 0 acts as 1; enable low holds
    add(4'h1,4'h0,4'h0,  0, 2,  6,0,2'd0,32'h04,4'hE,4'h0,0);
    add(4'h0,4'h0,4'h0,  0, 2,  6,1,2'd0,32'h04,4'hE,4'h0,0);
    // pingpong [0,10] step 4 with clamping at both ends
    add(4'h0,4'h0,4'h1,  0, 0, 10,4,2'd0,32'h00,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0, 10,4,2'd0,32'h04,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0, 10,4,2'd0,32'h08,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0, 10,4,2'd0,32'h0A,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0, 10,4,2'd0,32'h06,4'hE,4'h1,0);
    add(4'h1,4'h0,4'h0,  0, 0, 10,4,2'd0,32'h02,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0, 10,4,2'd0,32'h00,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0, 10,4,2'd0,32'h04,4'hF,4'h1,0);
    // wrap up near 8-bit ceiling, wrap down to 0
    add(4'h0,4'h0,4'h1,250,250,255,3,2'd1,32'hFA,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0,250,255,3,2'd1,32'hFD,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0,250,255,3,2'd1,32'hFF,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0,250,255,3,2'd1,32'hFA,4'hF,4'h1,0);
    add(4'h0,4'h0,4'h1,  5, 0,  5,2,2'd2,32'h05,4'hF,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0,  5,2,2'd2,32'h03,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0,  5,2,2'd2,32'h01,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0,  5,2,2'd2,32'h00,4'hE,4'h0,0);
    add(4'h1,4'h0,4'h0,  0, 0,  5,2,2'd2,32'h05,4'hE,4'h1,0);
    // bad config freezes everything, then per-channel loads, resync, min==max
    add(4'hF,4'hF,4'hF,200, 7,  3,1,2'd0,32'h00000005,4'hE,4'h0,1);
    add(4'h0,4'h0,4'h2,200,10, 20,1,2'd0,32'h00000A05,4'hE,4'h0,0);
    add(4'h0,4'h0,4'h4, 15,10, 20,1,2'd0,32'h000F0A05,4'hE,4'h0,0);
    add(4'h8,4'h0,4'h0,  0,10, 20,1,2'd0,32'h0A0F0A05,4'hE,4'h0,0);
    add(4'h4,4'h0,4'h0,  0,15, 15,1,2'd0,32'h0A0F0A05,4'hE,4'h0,0);

    @(negedge clk);
    chk("reset_out", out, 32'h0);
    chk("reset_dir", {28'h0, direction}, 32'hF);
    chk("reset_evt", {28'h0, evt}, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < vq.size(); k++) begin
      enable = vq[k].en; flip = vq[k].fl; load = vq[k].ld; load_val = vq[k].lv;
      min = vq[k].mn; max = vq[k].mx; step = vq[k].st; mode = vq[k].md;
      #1 chk($sformatf("v%0d_cfg", k), {31'h0, cfg_err}, {31'h0, vq[k].e_cfg});
      @(posedge clk); #1;
      chk($sformatf("v%0d_out", k), out, vq[k].e_out);
      chk($sformatf("v%0d_dir", k), {28'h0, direction}, {28'h0, vq[k].e_dir});
      chk($sformatf("v%0d_evt", k), {28'h0, evt}, {28'h0, vq[k].e_evt});
      @(negedge clk);
    end

    // oneshot [0,3] on ch0: resync to 0, climb to 3 with evt, then async reset mid-cycle
    enable = 4'h1; flip = '0; load = '0; min = 0; max = 3; step = 1; mode = 2'd3;
    repeat (4) @(posedge clk);
    #1 chk("pre_rst_out", out, 32'h0A0F0A03);
    chk("pre_rst_evt", {28'h0, evt}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out", out, 32'h0);
    chk("async_rst_dir", {28'h0, direction}, 32'hF);
    chk("async_rst_evt", {28'h0, evt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nevt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("oneshot_%0d", k), out, (k < 3) ? k : 3);
      nevt += int'(evt[0]);
      chk($sformatf("oneshot_evt_%0d", k), {28'h0, evt}, {31'h0, k == 3});
    end
    chk("oneshot_evt_total", nevt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
